// File: rtl/dmrs_ls_estimator.sv
// Pairs regenerated PUSCH DMRS references with received DMRS REs and emits LS estimates H = rx * conj(ref).
// Optional macro DMRS_RB_AVG_EN: average the estimates over groups of 6 subcarriers.
module dmrs_ls_estimator #(
    parameter int RX_W       = 12,
    parameter int OUT_W      = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [9:0]              Mzc,
    input  logic signed [8:0]       DMRS_r,
    input  logic signed [8:0]       DMRS_i,
    input  logic                    DMRS_valid,
    input  logic signed [RX_W-1:0]  rx_r,
    input  logic signed [RX_W-1:0]  rx_i,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic signed [OUT_W-1:0] H_r,
    output logic signed [OUT_W-1:0] H_i,
    output logic                    H_valid,
    output logic                    H_last,
    output logic                    done,
    output logic                    ovf
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PROD_W = RX_W + 9;
    localparam int P_W    = RX_W + 10;
`ifdef DMRS_RB_AVG_EN
    localparam logic [1:0] FLUSH_LAST = 2'd2;
`else
    localparam logic [1:0] FLUSH_LAST = 2'd1;
`endif
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state_reg, state_next;

    logic [9:0]    mzc_reg, pair_cnt_reg;
    logic [1:0]    flush_cnt_reg;
    logic [17:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          ovf_reg, done_reg;

    logic start, fifo_full, fifo_empty, accept, last_pair, push, drop, flush_end;
    logic signed [8:0] d_r, d_i;

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [31:0] v);
        if (v > SAT_MAX)
            sat = SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN)
            sat = SAT_MIN[OUT_W-1:0];
        else
            sat = v[OUT_W-1:0];
    endfunction

    assign start      = (state_reg == IDLE) && enable && (Mzc != 10'd0);
    assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign rx_ready   = (state_reg == RUN) && !fifo_empty;
    assign accept     = rx_valid && rx_ready;
    assign last_pair  = (pair_cnt_reg == mzc_reg - 10'd1);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the new reference.
    assign push       = (state_reg == RUN) && DMRS_valid && (!fifo_full || accept);
    assign drop       = (state_reg == RUN) && DMRS_valid && fifo_full && !accept;
    assign flush_end  = (state_reg == FLUSH) && (flush_cnt_reg == FLUSH_LAST);
    assign {d_r, d_i} = fifo_mem[rd_ptr_reg];
    assign ovf        = ovf_reg;
    assign done       = done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last_pair) state_next = FLUSH;
            FLUSH:   if (flush_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mzc_reg       <= '0;
            pair_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg      <= flush_end;
            flush_cnt_reg <= (state_reg == FLUSH) ? flush_cnt_reg + 2'd1 : 2'd0;
            if (start) begin
                mzc_reg      <= Mzc;
                pair_cnt_reg <= '0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                ovf_reg      <= 1'b0;
            end else begin
                if (accept) begin
                    pair_cnt_reg <= pair_cnt_reg + 10'd1;
                    rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                end
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(accept);
                if (drop)
                    ovf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {DMRS_r, DMRS_i};
    end

    // Stage 1: the four partial products of rx * conj(ref).
    logic signed [PROD_W-1:0] s1_rr, s1_ii, s1_ir, s1_ri;
    logic                     s1_valid, s1_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_rr    <= '0;
            s1_ii    <= '0;
            s1_ir    <= '0;
            s1_ri    <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept && last_pair;
            if (accept) begin
                s1_rr <= PROD_W'(rx_r) * PROD_W'(d_r);
                s1_ii <= PROD_W'(rx_i) * PROD_W'(d_i);
                s1_ir <= PROD_W'(rx_i) * PROD_W'(d_r);
                s1_ri <= PROD_W'(rx_r) * PROD_W'(d_i);
            end
        end
    end

    // Stage 2: combine, drop the Q1.8 reference scaling, saturate.
    logic signed [P_W-1:0]   p_r, p_i;
    logic signed [OUT_W-1:0] s2_r, s2_i;
    logic                    s2_valid, s2_last;

    assign p_r = P_W'(s1_rr) + P_W'(s1_ii);
    assign p_i = P_W'(s1_ir) - P_W'(s1_ri);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_r     <= '0;
            s2_i     <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_r <= sat(32'(p_r >>> 8));
                s2_i <= sat(32'(p_i >>> 8));
            end
        end
    end

`ifdef DMRS_RB_AVG_EN
    localparam int ACC_W = OUT_W + 3;
    logic signed [ACC_W-1:0] acc_r_reg, acc_i_reg, sum_r, sum_i;
    logic signed [31:0]      scl_r, scl_i;
    logic signed [OUT_W-1:0] avg_r_reg, avg_i_reg;
    logic [2:0]              grp_cnt_reg;
    logic                    grp_end, avg_valid_reg, avg_last_reg;

    assign sum_r   = acc_r_reg + ACC_W'(s2_r);
    assign sum_i   = acc_i_reg + ACC_W'(s2_i);
    // 683/4096 approximates 1/6; a short trailing group is still divided by 6.
    assign scl_r   = (32'(sum_r) * 32'sd683) >>> 12;
    assign scl_i   = (32'(sum_i) * 32'sd683) >>> 12;
    assign grp_end = s2_valid && (s2_last || grp_cnt_reg == 3'd5);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r_reg     <= '0;
            acc_i_reg     <= '0;
            avg_r_reg     <= '0;
            avg_i_reg     <= '0;
            grp_cnt_reg   <= '0;
            avg_valid_reg <= 1'b0;
            avg_last_reg  <= 1'b0;
        end else begin
            avg_valid_reg <= grp_end;
            avg_last_reg  <= grp_end && s2_last;
            if (grp_end) begin
                avg_r_reg   <= sat(scl_r);
                avg_i_reg   <= sat(scl_i);
                acc_r_reg   <= '0;
                acc_i_reg   <= '0;
                grp_cnt_reg <= '0;
            end else if (s2_valid) begin
                acc_r_reg   <= sum_r;
                acc_i_reg   <= sum_i;
                grp_cnt_reg <= grp_cnt_reg + 3'd1;
            end
        end
    end

    assign H_r     = avg_r_reg;
    assign H_i     = avg_i_reg;
    assign H_valid = avg_valid_reg;
    assign H_last  = avg_last_reg;
`else
    assign H_r     = s2_r;
    assign H_i     = s2_i;
    assign H_valid = s2_valid;
    assign H_last  = s2_last;
`endif

endmodule
